// File: rtl/system_clock_en_ctrl.sv
// system_clock_en_ctrl
// Initiator side of the system clock-enable path. Software or debug asks to
// gate or ungate the target domain over a valid/ready handshake. Gating waits
// for a programmable run of idle cycles and gives up after a drain timeout.
// Ungating happens on request or on a wake event, and its completion is
// reported once clock_en has been high for WAKE_DELAY cycles.
module system_clock_en_ctrl #(
    parameter int unsigned IDLE_CYCLES   = 4,
    parameter int unsigned DRAIN_TIMEOUT = 256,
    parameter int unsigned WAKE_DELAY    = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_en,
    input  logic       idle,
    input  logic       wake,
    output logic       clock_en,
    output logic       resp_valid,
    output logic [1:0] resp_status,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_GATED = 2'b10,
        ST_WAKE  = 2'b11
    } state_t;

    localparam logic [1:0] STS_DONE      = 2'b00;
    localparam logic [1:0] STS_TIMEOUT   = 2'b01;
    localparam logic [1:0] STS_REDUNDANT = 2'b10;
    localparam logic [1:0] STS_WOKEN     = 2'b11;

    // Counter widths hold 0..param; the wake counter needs at least one bit
    // even when WAKE_DELAY is zero.
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
    localparam int WW = (WAKE_DELAY == 0) ? 1 : $clog2(WAKE_DELAY + 1);

    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_SAT  = IW'(IDLE_CYCLES);
    localparam logic [TW-1:0] TOUT_LAST = TW'(DRAIN_TIMEOUT - 1);
    localparam logic [TW-1:0] TOUT_SAT  = TW'(DRAIN_TIMEOUT);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_DELAY);

    state_t        state_r, state_nxt;
    logic [IW-1:0] idle_cnt_r, idle_cnt_nxt;
    logic [TW-1:0] tout_cnt_r, tout_cnt_nxt;
    logic [WW-1:0] wake_cnt_r, wake_cnt_nxt;
    logic          cause_wake_r, cause_wake_nxt;
    logic          clock_en_r, clock_en_nxt;
    logic          req_ready_r, req_ready_nxt;
    logic          resp_valid_r, resp_valid_nxt;
    logic [1:0]    resp_status_r, resp_status_nxt;
    logic          accept_s;
    logic          idle_hit_s;
    logic          tout_hit_s;

    assign accept_s   = req_valid && ((state_r == ST_RUN) || (state_r == ST_GATED));
    assign idle_hit_s = idle && (idle_cnt_r == IDLE_LAST);
    assign tout_hit_s = (tout_cnt_r == TOUT_LAST);

    assign req_ready   = req_ready_r;
    assign clock_en    = clock_en_r;
    assign resp_valid  = resp_valid_r;
    assign resp_status = resp_status_r;
    assign state_o     = state_r;

    // State, counters and registered outputs; reset restores the running state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r       <= ST_RUN;
            idle_cnt_r    <= '0;
            tout_cnt_r    <= '0;
            wake_cnt_r    <= '0;
            cause_wake_r  <= 1'b0;
            clock_en_r    <= 1'b1;
            req_ready_r   <= 1'b1;
            resp_valid_r  <= 1'b0;
            resp_status_r <= STS_DONE;
        end else begin
            state_r       <= state_nxt;
            idle_cnt_r    <= idle_cnt_nxt;
            tout_cnt_r    <= tout_cnt_nxt;
            wake_cnt_r    <= wake_cnt_nxt;
            cause_wake_r  <= cause_wake_nxt;
            clock_en_r    <= clock_en_nxt;
            req_ready_r   <= req_ready_nxt;
            resp_valid_r  <= resp_valid_nxt;
            resp_status_r <= resp_status_nxt;
        end
    end

    // Next-state and counter logic; idle completion beats drain timeout.
    always_comb begin
        state_nxt      = state_r;
        idle_cnt_nxt   = idle_cnt_r;
        tout_cnt_nxt   = tout_cnt_r;
        wake_cnt_nxt   = wake_cnt_r;
        cause_wake_nxt = cause_wake_r;
        case (state_r)
            ST_RUN: begin
                if (accept_s && !req_en) begin
                    state_nxt    = ST_DRAIN;
                    idle_cnt_nxt = '0;
                    tout_cnt_nxt = '0;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (idle_hit_s) begin
                    state_nxt = ST_GATED;
                end else if (tout_hit_s) begin
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_DRAIN;
                end
                if (!idle) begin
                    idle_cnt_nxt = '0;
                end else if (idle_cnt_r != IDLE_SAT) begin
                    idle_cnt_nxt = idle_cnt_r + IW'(1);
                end else begin
                    idle_cnt_nxt = idle_cnt_r;
                end
                if (tout_cnt_r != TOUT_SAT) begin
                    tout_cnt_nxt = tout_cnt_r + TW'(1);
                end else begin
                    tout_cnt_nxt = tout_cnt_r;
                end
            end
            ST_GATED: begin
                if (accept_s) begin
                    if (req_en) begin
                        state_nxt      = ST_WAKE;
                        wake_cnt_nxt   = '0;
                        cause_wake_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_GATED;
                    end
                end else if (wake) begin
                    state_nxt      = ST_WAKE;
                    wake_cnt_nxt   = '0;
                    cause_wake_nxt = 1'b1;
                end else begin
                    state_nxt = ST_GATED;
                end
            end
            ST_WAKE: begin
                if (wake_cnt_r == WAKE_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt    = ST_WAKE;
                    wake_cnt_nxt = wake_cnt_r + WW'(1);
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Output decode: clock_en follows the state one cycle late, responses
    // pulse on the edge that completes a request.
    always_comb begin
        clock_en_nxt    = (state_r != ST_GATED);
        req_ready_nxt   = (state_nxt == ST_RUN) || (state_nxt == ST_GATED);
        resp_valid_nxt  = 1'b0;
        resp_status_nxt = resp_status_r;
        case (state_r)
            ST_RUN: begin
                if (accept_s && req_en) begin
                    resp_valid_nxt  = 1'b1;
                    resp_status_nxt = STS_REDUNDANT;
                end else begin
                    resp_valid_nxt = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (state_nxt == ST_GATED) begin
                    resp_valid_nxt  = 1'b1;
                    resp_status_nxt = STS_DONE;
                end else if (state_nxt == ST_RUN) begin
                    resp_valid_nxt  = 1'b1;
                    resp_status_nxt = STS_TIMEOUT;
                end else begin
                    resp_valid_nxt = 1'b0;
                end
            end
            ST_GATED: begin
                if (accept_s && !req_en) begin
                    resp_valid_nxt  = 1'b1;
                    resp_status_nxt = STS_REDUNDANT;
                end else begin
                    resp_valid_nxt = 1'b0;
                end
            end
            ST_WAKE: begin
                if (state_nxt == ST_RUN) begin
                    resp_valid_nxt  = 1'b1;
                    resp_status_nxt = cause_wake_r ? STS_WOKEN : STS_DONE;
                end else begin
                    resp_valid_nxt = 1'b0;
                end
            end
            default: begin
                resp_valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_system_clock_en_ctrl.sv
// Testbench for system_clock_en_ctrl: a table of per-cycle vectors drives
// instance A (IDLE=4, TIMEOUT=16, WAKE_DELAY=2); hand-written sequences drive
// instance B (IDLE=4, TIMEOUT=4, WAKE_DELAY=0) for the boundary cases.
module tb_system_clock_en_ctrl;

    localparam logic [1:0] RUN = 2'b00;
    localparam logic [1:0] DRN = 2'b01;
    localparam logic [1:0] GTD = 2'b10;
    localparam logic [1:0] WAK = 2'b11;

    logic clock = 1'b0;

    logic       a_reset_n, a_req_valid, a_req_en, a_idle, a_wake;
    logic       a_req_ready, a_clock_en, a_resp_valid;
    logic [1:0] a_resp_status, a_state;

    logic       b_reset_n, b_req_valid, b_req_en, b_idle, b_wake;
    logic       b_req_ready, b_clock_en, b_resp_valid;
    logic [1:0] b_resp_status, b_state;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       rv;
        logic       en;
        logic       idl;
        logic       wk;
        logic       rst;
        logic [1:0] st;
        logic       ce;
        logic       rdy;
        logic       vld;
        logic [1:0] sts;
    } vec_t;

    vec_t tbl[$];

    system_clock_en_ctrl #(.IDLE_CYCLES(4), .DRAIN_TIMEOUT(16), .WAKE_DELAY(2)) dut_a (
        .clock(clock), .reset_n(a_reset_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_en(a_req_en), .idle(a_idle), .wake(a_wake), .clock_en(a_clock_en),
        .resp_valid(a_resp_valid), .resp_status(a_resp_status), .state_o(a_state)
    );

    system_clock_en_ctrl #(.IDLE_CYCLES(4), .DRAIN_TIMEOUT(4), .WAKE_DELAY(0)) dut_b (
        .clock(clock), .reset_n(b_reset_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_en(b_req_en), .idle(b_idle), .wake(b_wake), .clock_en(b_clock_en),
        .resp_valid(b_resp_valid), .resp_status(b_resp_status), .state_o(b_state)
    );

    always #5 clock = ~clock;

    function automatic void add(input logic rv, input logic en, input logic idl, input logic wk,
                                input logic rst, input logic [1:0] st, input logic ce,
                                input logic rdy, input logic vld, input logic [1:0] sts);
        vec_t v;
        v.rv = rv; v.en = en; v.idl = idl; v.wk = wk; v.rst = rst;
        v.st = st; v.ce = ce; v.rdy = rdy; v.vld = vld; v.sts = sts;
        tbl.push_back(v);
    endfunction

    // Gate request with idle held high: DRAIN for four edges, GATED with
    // response on the fourth, clock_en low one edge later.
    function automatic void add_gate();
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, DRN, 1'b1, 1'b0, 1'b0, 2'b00);
        for (int k = 1; k <= 3; k++)
            add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, DRN, 1'b1, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, GTD, 1'b1, 1'b1, 1'b1, 2'b00);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, GTD, 1'b0, 1'b1, 1'b0, 2'b00);
    endfunction

    task automatic check(input string nm, input logic [6:0] got, input logic [6:0] exp,
                         input logic chk_sts);
        logic [6:0] mask;
        mask = chk_sts ? 7'h7F : 7'h7C;
        n_vec++;
        if ((got & mask) !== (exp & mask)) begin
            n_err++;
            $display("FAIL %s: got st/ce/rdy/vld/sts=%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b",
                     nm, got[6:5], got[4], got[3], got[2], got[1:0],
                     exp[6:5], exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    task automatic step_b(input logic rv, input logic en, input logic idl, input logic wk,
                          input logic rst);
        b_req_valid = rv; b_req_en = en; b_idle = idl; b_wake = wk; b_reset_n = rst;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_b(input string nm, input logic [1:0] st, input logic ce, input logic rdy,
                         input logic vld, input logic [1:0] sts);
        check(nm, {b_state, b_clock_en, b_req_ready, b_resp_valid, b_resp_status},
              {st, ce, rdy, vld, sts}, vld);
    endtask

    initial begin
        a_reset_n = 1'b0; a_req_valid = 1'b0; a_req_en = 1'b0; a_idle = 1'b0; a_wake = 1'b0;
        b_reset_n = 1'b0; b_req_valid = 1'b0; b_req_en = 1'b0; b_idle = 1'b0; b_wake = 1'b0;

        // reset, redundant ungates in RUN (back-to-back)
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RUN, 1'b1, 1'b1, 1'b0, 2'b00);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RUN, 1'b1, 1'b1, 1'b0, 2'b00);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, RUN, 1'b1, 1'b1, 1'b1, 2'b10);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, RUN, 1'b1, 1'b1, 1'b1, 2'b10);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RUN, 1'b1, 1'b1, 1'b0, 2'b00);
        // gate, redundant gate, ungate by request (held request/wake ignored in WAKE)
        add_gate();
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, GTD, 1'b0, 1'b1, 1'b1, 2'b10);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, GTD, 1'b0, 1'b1, 1'b0, 2'b00);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, WAK, 1'b0, 1'b0, 1'b0, 2'b00);
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, WAK, 1'b1, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, WAK, 1'b1, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RUN, 1'b1, 1'b1, 1'b1, 2'b00);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RUN, 1'b1, 1'b1, 1'b0, 2'b00);
        // gate, then one-cycle wake pulse
        add_gate();
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, WAK, 1'b0, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, WAK, 1'b1, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, WAK, 1'b1, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RUN, 1'b1, 1'b1, 1'b1, 2'b11);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RUN, 1'b1, 1'b1, 1'b0, 2'b00);
        // gate, then request and wake together: request wins
        add_gate();
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, WAK, 1'b0, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, WAK, 1'b1, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, WAK, 1'b1, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RUN, 1'b1, 1'b1, 1'b1, 2'b00);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RUN, 1'b1, 1'b1, 1'b0, 2'b00);
        // idle pattern 1,1,1,0 never completes; timeout at edge 16
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, DRN, 1'b1, 1'b0, 1'b0, 2'b00);
        for (int k = 1; k <= 15; k++)
            add(1'b0, 1'b0, ((k % 4) != 0), 1'b0, 1'b1, DRN, 1'b1, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RUN, 1'b1, 1'b1, 1'b1, 2'b01);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, RUN, 1'b1, 1'b1, 1'b0, 2'b00);
        // reset mid-DRAIN, then no spurious response
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, DRN, 1'b1, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, DRN, 1'b1, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, RUN, 1'b1, 1'b1, 1'b0, 2'b00);
        for (int k = 0; k < 4; k++)
            add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, RUN, 1'b1, 1'b1, 1'b0, 2'b00);
        // reset mid-WAKE: clock_en returns high at the reset edge
        add_gate();
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, WAK, 1'b0, 1'b0, 1'b0, 2'b00);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RUN, 1'b1, 1'b1, 1'b0, 2'b00);
        for (int k = 0; k < 3; k++)
            add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, RUN, 1'b1, 1'b1, 1'b0, 2'b00);

        foreach (tbl[i]) begin
            a_req_valid = tbl[i].rv; a_req_en = tbl[i].en; a_idle = tbl[i].idl;
            a_wake = tbl[i].wk; a_reset_n = tbl[i].rst;
            @(posedge clock);
            #1;
            check($sformatf("a_row%0d", i),
                  {a_state, a_clock_en, a_req_ready, a_resp_valid, a_resp_status},
                  {tbl[i].st, tbl[i].ce, tbl[i].rdy, tbl[i].vld, tbl[i].sts},
                  tbl[i].vld | ~tbl[i].rst);
        end
        a_req_valid = 1'b0; a_wake = 1'b0;

        // B: idle and timeout both reach their limit on edge 4 -> idle wins
        step_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_b("b_reset", RUN, 1'b1, 1'b1, 1'b0, 2'b00);
        step_b(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk_b("b_drain_entry", DRN, 1'b1, 1'b0, 1'b0, 2'b00);
        for (int k = 1; k <= 3; k++) step_b(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk_b("b_drain_e3", DRN, 1'b1, 1'b0, 1'b0, 2'b00);
        step_b(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk_b("b_tie_gates", GTD, 1'b1, 1'b1, 1'b1, 2'b00);
        step_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_b("b_gated_ce", GTD, 1'b0, 1'b1, 1'b0, 2'b00);
        // B: WAKE_DELAY=0 -> WAKE lasts exactly one cycle
        step_b(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_b("b_wake_entry", WAK, 1'b0, 1'b0, 1'b0, 2'b00);
        step_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_b("b_wake_done", RUN, 1'b1, 1'b1, 1'b1, 2'b11);
        // B: idle low throughout -> timeout on edge 4
        step_b(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_b("b_to_entry", DRN, 1'b1, 1'b0, 1'b0, 2'b00);
        for (int k = 1; k <= 3; k++) step_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_b("b_to_e3", DRN, 1'b1, 1'b0, 1'b0, 2'b00);
        step_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_b("b_timeout", RUN, 1'b1, 1'b1, 1'b1, 2'b01);
        step_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_b("b_after_to", RUN, 1'b1, 1'b1, 1'b0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
